// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Bits needed for a down-counter that holds (largest cycle count - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : unsigned'($clog2(m));
  endfunction

endpackage

// File: rtl/sync2_bit.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync2_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock supervisor: drives the PLL reset, holds sys_rst until
// lock has been stable, and re-sequences the PLL on loss of lock.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 27000,
  parameter int unsigned LOCK_STABLE  = 2700,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  localparam logic [CW-1:0] RST_LOAD     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LOAD  = CW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

  logic lock_s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  sync2_bit u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state, shared counter, statistics and registered output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == '0) state_d = ST_WAIT_LOCK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == '0) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = ST_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s)           state_d = ST_WAIT_LOCK;
        else if (cnt_q == '0)  state_d = ST_RUN;
        else                   cnt_d   = cnt_q - CW'(1);
      end
      ST_RUN: begin
        // A lock loss is counted even when a relock request arrives with it.
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (relock_req) begin
          state_d = ST_PLL_RST;
        end
      end
      ST_FAIL: begin
        if (relock_req) begin
          state_d = ST_PLL_RST;
          retry_d = '0;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    if (state_d == ST_RUN) retry_d = '0;

    // Reload the shared counter on every state entry.
    if (state_d != state_q) begin
      case (state_d)
        ST_PLL_RST:   cnt_d = RST_LOAD;
        ST_WAIT_LOCK: cnt_d = TIMEOUT_LOAD;
        ST_STABLE:    cnt_d = STABLE_LOAD;
        default:      cnt_d = '0;
      endcase
    end

    pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    sys_rst_d   = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= RST_LOAD;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed vector table,
// multi-cycle corner sequences and random stimulus against a phase model.
module tb_pll_lock_sequencer;

  localparam int unsigned P_RST    = 4;
  localparam int unsigned P_TMO    = 16;
  localparam int unsigned P_STABLE = 8;
  localparam int unsigned P_RETRY  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int errors = 0;
  int checks = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (P_RST),
    .LOCK_TIMEOUT (P_TMO),
    .LOCK_STABLE  (P_STABLE),
    .MAX_RETRY    (P_RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] got_vec;
  assign got_vec = {pll_reset, sys_rst, ready, fail, retry_cnt, loss_cnt};

  function automatic logic [15:0] ex(input logic pr, input logic sr,
                                     input logic rd, input logic fl,
                                     input int unsigned rt, input int unsigned lo);
    return {pr, sr, rd, fl, 4'(rt), 8'(lo)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {prst,srst,rdy,fail,retry,loss}=%h required=%h at %0t",
               name, got, exp, $time);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        r;
    logic        lk;
    logic        rq;
    int          ncyc;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic lk, input logic rq,
                     input int n, input logic [15:0] e);
    vec_t v;
    v.r = r; v.lk = lk; v.rq = rq; v.ncyc = n; v.exp = e;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAIL} mphase_e;

  mphase_e     m_phase;
  int unsigned m_elapsed;
  int unsigned m_retries;
  int unsigned m_losses;
  bit          m_hist[2];

  task automatic model_reset();
    m_phase   = M_RESET;
    m_elapsed = 0;
    m_retries = 0;
    m_losses  = 0;
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
  endtask

  task automatic model_step(input logic lk, input logic rq);
    bit      ls;
    mphase_e nxt;
    ls  = m_hist[1];
    nxt = m_phase;
    case (m_phase)
      M_RESET: begin
        m_elapsed++;
        if (m_elapsed == P_RST) nxt = M_WAIT;
      end
      M_WAIT: begin
        if (ls) nxt = M_STABLE;
        else begin
          m_elapsed++;
          if (m_elapsed == P_TMO) begin
            if (m_retries == P_RETRY) nxt = M_FAIL;
            else begin m_retries++; nxt = M_RESET; end
          end
        end
      end
      M_STABLE: begin
        if (!ls) nxt = M_WAIT;
        else begin
          m_elapsed++;
          if (m_elapsed == P_STABLE) begin nxt = M_RUN; m_retries = 0; end
        end
      end
      M_RUN: begin
        if (!ls) begin
          nxt = M_RESET;
          m_losses = (m_losses < 255) ? m_losses + 1 : 255;
        end else if (rq) nxt = M_RESET;
      end
      M_FAIL: begin
        if (rq) begin nxt = M_RESET; m_retries = 0; end
      end
      default: nxt = M_RESET;
    endcase
    if (nxt != m_phase) m_elapsed = 0;
    m_phase   = nxt;
    m_hist[1] = m_hist[0];
    m_hist[0] = lk;
  endtask

  function automatic logic [15:0] model_out();
    return ex((m_phase == M_RESET) || (m_phase == M_FAIL), m_phase != M_RUN,
              m_phase == M_RUN, m_phase == M_FAIL, m_retries, m_losses);
  endfunction

  task automatic wait_ready(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int unsigned lock_left;
    int unsigned r;

    rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;

    //  rst lk rq  n   prst srst rdy fail retry loss
    add(1, 0, 0,  2, ex(1, 1, 0, 0, 0, 0));  // in reset
    add(0, 0, 0,  3, ex(1, 1, 0, 0, 0, 0));  // PLL reset pulse
    add(0, 0, 0,  1, ex(0, 1, 0, 0, 0, 0));  // 4 cycles after release
    add(0, 0, 0,  6, ex(0, 1, 0, 0, 0, 0));
    add(0, 1, 0, 10, ex(0, 1, 0, 0, 0, 0));  // lock rises 10 after release
    add(0, 1, 0,  1, ex(0, 0, 1, 0, 0, 0));  // ready 11 after lock edge
    add(0, 0, 0,  2, ex(0, 0, 1, 0, 0, 0));  // loss not yet visible
    add(0, 0, 0,  1, ex(1, 1, 0, 0, 0, 1));  // sys_rst 3 cycles after loss
    add(0, 0, 0,  3, ex(1, 1, 0, 0, 0, 1));  // never locks from here
    add(0, 0, 0,  1, ex(0, 1, 0, 0, 0, 1));
    add(0, 0, 0, 15, ex(0, 1, 0, 0, 0, 1));
    add(0, 0, 0,  1, ex(1, 1, 0, 0, 1, 1));  // first timeout
    add(0, 0, 0, 24, ex(0, 1, 0, 0, 2, 1));
    add(0, 0, 0, 15, ex(0, 1, 0, 0, 2, 1));
    add(0, 0, 0,  1, ex(1, 1, 0, 1, 2, 1));  // FAIL
    add(0, 0, 0,  5, ex(1, 1, 0, 1, 2, 1));
    add(0, 0, 1,  1, ex(1, 1, 0, 0, 0, 1));  // relock exits FAIL
    add(0, 1, 0,  3, ex(1, 1, 0, 0, 0, 1));
    add(0, 1, 0,  1, ex(0, 1, 0, 0, 0, 1));
    add(0, 1, 0,  1, ex(0, 1, 0, 0, 0, 1));
    add(0, 1, 0,  7, ex(0, 1, 0, 0, 0, 1));
    add(0, 1, 0,  1, ex(0, 0, 1, 0, 0, 1));
    add(0, 1, 1,  1, ex(1, 1, 0, 0, 0, 1));  // relock in RUN, no loss
    add(0, 1, 0,  4, ex(0, 1, 0, 0, 0, 1));
    add(0, 1, 0,  8, ex(0, 1, 0, 0, 0, 1));
    add(0, 1, 0,  1, ex(0, 0, 1, 0, 0, 1));
    add(0, 0, 0,  2, ex(0, 0, 1, 0, 0, 1));
    add(0, 0, 1,  1, ex(1, 1, 0, 0, 0, 2));  // relock + loss together
    add(0, 0, 0,  4, ex(0, 1, 0, 0, 0, 2));
    add(0, 1, 0,  5, ex(0, 1, 0, 0, 0, 2));  // glitch: 5 high
    add(0, 0, 0,  1, ex(0, 1, 0, 0, 0, 2));  // 1 low
    add(0, 1, 0, 10, ex(0, 1, 0, 0, 0, 2));  // STABLE window restarted
    add(0, 1, 0,  1, ex(0, 0, 1, 0, 0, 2));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; pll_lock = tbl[i].lk; relock_req = tbl[i].rq;
      for (int k = 0; k < tbl[i].ncyc; k++) begin
        @(posedge clk);
        #1 relock_req = 1'b0;
      end
      @(negedge clk);
      check($sformatf("vec%0d", i), got_vec, tbl[i].exp);
    end

    // Repeated lock losses saturate the loss counter.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sat_loss", got_vec, ex(1, 1, 0, 0, 0, (3 + i > 255) ? 255 : 3 + i));
      pll_lock = 1'b1;
      wait_ready(40, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sat_ready: ready=%b required=1 within 40 cycles", ready);
        break;
      end
    end
    check("sat_final", got_vec, ex(0, 0, 1, 0, 0, 255));

    // Short async reset pulse while in STABLE.
    relock_req = 1'b1;
    @(posedge clk);
    #1 relock_req = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre_rst_stable", got_vec, ex(0, 1, 0, 0, 0, 255));
    #2 rst = 1'b1;
    #1 check("async_rst", got_vec, ex(1, 1, 0, 0, 0, 0));
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("restart_prst", got_vec, ex(1, 1, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check("restart_wait", got_vec, ex(0, 1, 0, 0, 0, 0));
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("restart_stable", got_vec, ex(0, 1, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check("restart_run", got_vec, ex(0, 0, 1, 0, 0, 0));

    // Random stimulus against the reference model.
    rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    lock_left = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (lock_left == 0) begin
        r = $urandom_range(0, 99);
        if (r < 65) begin
          pll_lock = 1'b1; lock_left = $urandom_range(5, 60);
        end else if (r < 90) begin
          pll_lock = 1'b0; lock_left = $urandom_range(1, 6);
        end else begin
          pll_lock = 1'b0; lock_left = $urandom_range(20, 90);
        end
      end
      lock_left--;
      relock_req = ($urandom_range(0, 24) == 0);
      @(posedge clk);
      model_step(pll_lock, relock_req);
      @(negedge clk);
      check("rand", got_vec, model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
